// File: rtl/flow_volume_integrator_pkg.sv
// Shared state encoding for the flow-volume integrator.
// ST_INTEGRATE=2 matches the existing state-bus decoders.
package flow_volume_integrator_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_INTEGRATE = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_ARMED     = ST_ARMED,
        S_INTEGRATE = ST_INTEGRATE,
        S_DONE      = ST_DONE
    } state_e;

endpackage

// File: rtl/flow_volume_integrator_acc.sv
// Saturating volume accumulator with clear, enable and sticky clamp flag.
// ovAccNext is the value the next enabled sample would produce.
module sat_accumulator #(
    parameter int DATA_W = 8,
    parameter int VOL_W  = 16
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iClr,
    input  logic              iEn,
    input  logic [DATA_W-1:0] ivDin,
    output logic [VOL_W-1:0]  ovAcc,
    output logic [VOL_W-1:0]  ovAccNext,
    output logic              oSat
);

    logic [VOL_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [VOL_W:0]   sum;
    logic             ovf;

    always_comb begin
        sum       = {1'b0, acc_q} + {{(VOL_W + 1 - DATA_W){1'b0}}, ivDin};
        ovf       = sum[VOL_W];
        ovAccNext = ovf ? '1 : sum[VOL_W-1:0];
        acc_d     = acc_q;
        sat_d     = sat_q;
        if (iClr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (iEn) begin
            acc_d = ovAccNext;
            sat_d = sat_q | ovf;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign ovAcc = acc_q;
    assign oSat  = sat_q;

endmodule

// File: rtl/flow_volume_integrator.sv
// Breath-manoeuvre volume integrator: onset/end FSM, FEV1 capture,
// peak flow and sample count on top of a saturating accumulator.
module flow_volume_integrator
    import flow_volume_integrator_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int VOL_W        = 16,
    parameter int CNT_W        = 12,
    parameter int MIN_FLOW     = 4,
    parameter int IDLE_SAMPLES = 8
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iCE,
    input  logic [DATA_W-1:0] ivDatos,
    input  logic              iStart,
    input  logic [CNT_W-1:0]  ivFev1Samples,
    output logic [VOL_W-1:0]  ovVolumen,
    output logic [VOL_W-1:0]  ovFev1,
    output logic [DATA_W-1:0] ovPeakFlow,
    output logic [CNT_W-1:0]  ovSampleCount,
    output logic              oBusy,
    output logic              oDone,
    output logic              oSaturated
);

    localparam int LOW_W = $clog2(IDLE_SAMPLES + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [LOW_W-1:0]  low_q, low_d, low_inc;
    logic [VOL_W-1:0]  fev1_q, fev1_d, acc_next;
    logic              capt_q, capt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clr, accept, is_low, last, match;

    sat_accumulator #(
        .DATA_W (DATA_W),
        .VOL_W  (VOL_W)
    ) u_acc (
        .iClk      (iClk),
        .iReset    (iReset),
        .iClr      (clr),
        .iEn       (accept),
        .ivDin     (ivDatos),
        .ovAcc     (ovVolumen),
        .ovAccNext (acc_next),
        .oSat      (oSaturated)
    );

    always_comb begin
        clr     = (state_q == S_IDLE) && iStart;
        is_low  = ivDatos < DATA_W'(MIN_FLOW);
        accept  = iCE && (((state_q == S_ARMED) && !is_low) ||
                          (state_q == S_INTEGRATE));
        cnt_inc = cnt_q + 1'b1;
        low_inc = is_low ? low_q + 1'b1 : '0;
        last    = accept && ((low_inc == LOW_W'(IDLE_SAMPLES)) || (&cnt_inc));
        match   = accept && (|tgt_q) && (cnt_inc == tgt_q);

        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        low_d   = low_q;
        fev1_d  = fev1_q;
        capt_d  = capt_q;

        unique case (state_q)
            S_IDLE:      if (iStart) state_d = S_ARMED;
            S_ARMED:     if (accept) state_d = last ? S_DONE : S_INTEGRATE;
            S_INTEGRATE: if (last) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        if (clr) begin
            tgt_d  = ivFev1Samples;
            cnt_d  = '0;
            peak_d = '0;
            low_d  = '0;
            fev1_d = '0;
            capt_d = 1'b0;
        end else if (accept) begin
            cnt_d  = cnt_inc;
            low_d  = low_inc;
            peak_d = (ivDatos > peak_q) ? ivDatos : peak_q;
            capt_d = capt_q | match;
            // A short manoeuvre reports its final volume as FEV1
            if (match || (last && !capt_q)) fev1_d = acc_next;
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_INTEGRATE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
            peak_q  <= '0;
            low_q   <= '0;
            fev1_q  <= '0;
            capt_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
            low_q   <= low_d;
            fev1_q  <= fev1_d;
            capt_q  <= capt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ovFev1        = fev1_q;
    assign ovPeakFlow    = peak_q;
    assign ovSampleCount = cnt_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;

endmodule

// File: tb/tb_flow_volume_integrator.sv
// Bench for flow_volume_integrator: three parameterisations share stimulus
// and are compared every cycle against a behavioural manoeuvre model.
module tb_flow_volume_integrator;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [7:0]  din;
    logic        start;
    logic [11:0] fev1n;

    logic [15:0] a_vol, a_fev;
    logic [7:0]  a_peak;
    logic [11:0] a_cnt;
    logic        a_busy, a_done, a_sat;

    logic [9:0]  b_vol, b_fev;
    logic [7:0]  b_peak;
    logic [11:0] b_cnt;
    logic        b_busy, b_done, b_sat;

    logic [15:0] c_vol, c_fev;
    logic [7:0]  c_peak;
    logic [3:0]  c_cnt;
    logic        c_busy, c_done, c_sat;

    int tests = 0;
    int fails = 0;

    flow_volume_integrator #(.IDLE_SAMPLES(3)) dut_a (
        .iClk(clk), .iReset(rst), .iCE(ce), .ivDatos(din), .iStart(start),
        .ivFev1Samples(fev1n), .ovVolumen(a_vol), .ovFev1(a_fev),
        .ovPeakFlow(a_peak), .ovSampleCount(a_cnt), .oBusy(a_busy),
        .oDone(a_done), .oSaturated(a_sat));

    flow_volume_integrator #(.VOL_W(10), .IDLE_SAMPLES(3)) dut_b (
        .iClk(clk), .iReset(rst), .iCE(ce), .ivDatos(din), .iStart(start),
        .ivFev1Samples(fev1n), .ovVolumen(b_vol), .ovFev1(b_fev),
        .ovPeakFlow(b_peak), .ovSampleCount(b_cnt), .oBusy(b_busy),
        .oDone(b_done), .oSaturated(b_sat));

    flow_volume_integrator #(.CNT_W(4), .IDLE_SAMPLES(3)) dut_c (
        .iClk(clk), .iReset(rst), .iCE(ce), .ivDatos(din), .iStart(start),
        .ivFev1Samples(fev1n[3:0]), .ovVolumen(c_vol), .ovFev1(c_fev),
        .ovPeakFlow(c_peak), .ovSampleCount(c_cnt), .oBusy(c_busy),
        .oDone(c_done), .oSaturated(c_sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 armed, 2 integrating, 3 done
    typedef struct {
        int phase;
        int vol;
        int fev;
        int peak;
        int cnt;
        int low;
        int target;
        bit sat;
        bit captured;
    } mdl_t;

    localparam int MINF = 4;
    localparam int IDLE = 3;
    int VMAX[3]  = '{65535, 1023, 65535};
    int CMAX[3]  = '{4095, 4095, 15};
    int FMASK[3] = '{4095, 4095, 15};
    mdl_t m[3];

    function automatic mdl_t mdl_clear();
        mdl_t r;
        r.phase = 0; r.vol = 0; r.fev = 0; r.peak = 0; r.cnt = 0;
        r.low = 0; r.target = 0; r.sat = 0; r.captured = 0;
        return r;
    endfunction

    function automatic mdl_t take(mdl_t r, int k, int x);
        r.vol = r.vol + x;
        if (r.vol > VMAX[k]) begin
            r.vol = VMAX[k];
            r.sat = 1;
        end
        r.cnt++;
        if (x > r.peak) r.peak = x;
        r.low = (x < MINF) ? r.low + 1 : 0;
        r.phase = 2;
        if (r.target != 0 && r.cnt == r.target) begin
            r.fev = r.vol;
            r.captured = 1;
        end
        if (r.low >= IDLE || r.cnt == CMAX[k]) begin
            r.phase = 3;
            if (!r.captured) r.fev = r.vol;
        end
        return r;
    endfunction

    function automatic mdl_t step(mdl_t r, int k);
        case (r.phase)
            0: if (start) begin
                r = mdl_clear();
                r.target = int'(fev1n) & FMASK[k];
                r.phase = 1;
            end
            1: if (ce && din >= MINF) r = take(r, k, int'(din));
            2: if (ce) r = take(r, k, int'(din));
            default: r.phase = 0;
        endcase
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(string n, int k, int vol, int fev, int peak,
                            int cnt, bit busy, bit done, bit sat);
        chk({n, " vol"}, vol, m[k].vol);
        chk({n, " fev1"}, fev, m[k].fev);
        chk({n, " peak"}, peak, m[k].peak);
        chk({n, " count"}, cnt, m[k].cnt);
        chk({n, " busy"}, int'(busy), int'(m[k].phase == 1 || m[k].phase == 2));
        chk({n, " done"}, int'(done), int'(m[k].phase == 3));
        chk({n, " sat"}, int'(sat), int'(m[k].sat));
    endtask

    task automatic cmp_all();
        cmp_inst("A", 0, int'(a_vol), int'(a_fev), int'(a_peak), int'(a_cnt),
                 a_busy, a_done, a_sat);
        cmp_inst("B", 1, int'(b_vol), int'(b_fev), int'(b_peak), int'(b_cnt),
                 b_busy, b_done, b_sat);
        cmp_inst("C", 2, int'(c_vol), int'(c_fev), int'(c_peak), int'(c_cnt),
                 c_busy, c_done, c_sat);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) m[k] = step(m[k], k);
        cmp_all();
    endtask

    task automatic drive(bit s, bit c, int x);
        start = s;
        ce    = c;
        din   = 8'(x);
        tick();
    endtask

    typedef struct {
        bit s;
        bit c;
        int d;
        int vol;
        int fev;
        int cnt;
        int peak;
        bit busy;
        bit done;
    } vec_t;

    vec_t tbl[12];
    int   seq[9] = '{2, 10, 20, 30, 40, 50, 2, 1, 0};

    initial begin
        bit seen;
        tbl[0]  = '{1, 0, 0,   0,   0,   0, 0,  1, 0};
        tbl[1]  = '{0, 1, 2,   0,   0,   0, 0,  1, 0};
        tbl[2]  = '{0, 1, 10,  10,  0,   1, 10, 1, 0};
        tbl[3]  = '{0, 1, 20,  30,  0,   2, 20, 1, 0};
        tbl[4]  = '{0, 1, 30,  60,  0,   3, 30, 1, 0};
        tbl[5]  = '{0, 1, 40,  100, 100, 4, 40, 1, 0};
        tbl[6]  = '{0, 1, 50,  150, 100, 5, 50, 1, 0};
        tbl[7]  = '{0, 1, 2,   152, 100, 6, 50, 1, 0};
        tbl[8]  = '{0, 1, 1,   153, 100, 7, 50, 1, 0};
        tbl[9]  = '{0, 1, 0,   153, 100, 8, 50, 0, 1};
        tbl[10] = '{0, 0, 77,  153, 100, 8, 50, 0, 0};
        tbl[11] = '{0, 1, 99,  153, 100, 8, 50, 0, 0};

        rst = 1'b1; ce = 1'b0; din = '0; start = 1'b0; fev1n = '0;
        for (int k = 0; k < 3; k++) m[k] = mdl_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset vol", int'(a_vol), 0);
        chk("reset fev1", int'(a_fev), 0);
        chk("reset count", int'(a_cnt), 0);
        chk("reset busy", int'(a_busy), 0);
        chk("reset done", int'(a_done), 0);
        rst = 1'b0;
        tick();

        // Directed table, FEV1 at sample 4
        fev1n = 12'd4;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].s, tbl[i].c, tbl[i].d);
            chk($sformatf("tbl%0d vol", i), int'(a_vol), tbl[i].vol);
            chk($sformatf("tbl%0d fev1", i), int'(a_fev), tbl[i].fev);
            chk($sformatf("tbl%0d count", i), int'(a_cnt), tbl[i].cnt);
            chk($sformatf("tbl%0d peak", i), int'(a_peak), tbl[i].peak);
            chk($sformatf("tbl%0d busy", i), int'(a_busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d done", i), int'(a_done), int'(tbl[i].done));
        end

        // Short manoeuvre: FEV1 falls back to the final volume
        fev1n = 12'd20;
        drive(1, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, seq[i]);
        chk("short fev1", int'(a_fev), 153);
        chk("short done", int'(a_done), 1);
        drive(0, 0, 0);

        // Gaps with toggling data must match the gapless result
        fev1n = 12'd4;
        drive(1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, seq[i]);
            drive(0, 0, int'($urandom_range(0, 255)));
            drive(0, 0, int'($urandom_range(0, 255)));
        end
        chk("gap vol", int'(a_vol), 153);
        chk("gap fev1", int'(a_fev), 100);
        chk("gap count", int'(a_cnt), 8);
        chk("gap peak", int'(a_peak), 50);

        // Saturation in the 10-bit instance
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 255);
        chk("sat b vol", int'(b_vol), 1023);
        chk("sat b flag", int'(b_sat), 1);
        chk("sat a vol", int'(a_vol), 1275);
        chk("sat a flag", int'(a_sat), 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0);

        // Asynchronous reset mid-manoeuvre
        drive(1, 0, 0);
        drive(0, 1, 10);
        drive(0, 1, 20);
        drive(0, 1, 30);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) m[k] = mdl_clear();
        chk("arst vol", int'(a_vol), 0);
        chk("arst count", int'(a_cnt), 0);
        chk("arst peak", int'(a_peak), 0);
        chk("arst busy", int'(a_busy), 0);
        chk("arst done", int'(a_done), 0);
        @(posedge clk);
        #1;
        chk("arst hold done", int'(a_done), 0);
        rst = 1'b0;
        drive(0, 1, 50);
        chk("arst idle ignores", int'(a_vol), 0);

        // Count limit in the 4-bit instance, iStart ignored mid-manoeuvre
        fev1n = 12'd0;
        drive(1, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(i == 7, 1, 5);
            if (i == 7) begin
                chk("restart ignored count", int'(a_cnt), 8);
                chk("restart ignored busy", int'(a_busy), 1);
            end
            if (c_done) seen = 1'b1;
        end
        chk("cnt limit done seen", int'(seen), 1);
        chk("cnt limit count", int'(c_cnt), 15);
        chk("cnt limit vol", int'(c_vol), 75);
        chk("cnt limit fev1", int'(c_fev), 75);
        for (int i = 0; i < 5; i++) drive(0, 1, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            fev1n = 12'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0)
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 255)));
            else
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
